// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch over the SRAM-like req/addr_ok/data_ok bus,
// buffering returned instructions in order and handing {pc, inst} pairs to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ds_allowin,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int FW = $clog2(IBUF_DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [QW-1:0] Q_LAST  = QW'(MAX_OUTSTANDING - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          stale_q, stale_d;
    logic [31:0]   stale_pc_q, stale_pc_d;
    logic          pending_q, pending_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] cancel_q, cancel_d;
    logic [31:0]   pcq_q [MAX_OUTSTANDING];
    logic [31:0]   pcq_d [MAX_OUTSTANDING];
    logic [QW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [31:0]   fifo_pc_q [IBUF_DEPTH];
    logic [31:0]   fifo_pc_d [IBUF_DEPTH];
    logic [31:0]   fifo_inst_q [IBUF_DEPTH];
    logic [31:0]   fifo_inst_d [IBUF_DEPTH];
    logic [FW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [OW-1:0] live_cnt;
    logic          has_room;
    logic          fire;
    logic          resp;
    logic          live_resp;
    logic          live_fire;
    logic          pop;
    logic          unused_ok;

    // Handshakes: a request transfers when req && addr_ok, a response when data_ok,
    // and a decode hand-off when fs_valid && ds_allowin; req is never withdrawn.
    assign live_cnt      = out_q - cancel_q;
    assign has_room      = (32'(live_cnt) + 32'(fifo_cnt_q)) < 32'(IBUF_DEPTH);
    assign inst_sram_req = !reset && (pending_q || ((out_q < OUT_MAX) && has_room));
    assign fire          = inst_sram_req && inst_sram_addr_ok;
    assign resp          = inst_sram_data_ok;
    assign live_resp     = resp && !br_valid && (cancel_q == '0);
    assign live_fire     = fire && !br_valid && !stale_q;
    assign pop           = fs_valid && ds_allowin && !br_valid;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = stale_q ? stale_pc_q : fetch_pc_q;

    assign fs_valid = (fifo_cnt_q != '0);
    assign fs_pc    = fs_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
    assign fs_inst  = fs_valid ? fifo_inst_q[fifo_rd_q] : 32'h0;

    assign unused_ok = &{1'b0, br_target[1:0]};

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        stale_d     = stale_q;
        stale_pc_d  = stale_pc_q;
        pending_d   = inst_sram_req && !inst_sram_addr_ok;
        out_d       = out_q;
        cancel_d    = cancel_q;
        pcq_d       = pcq_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_rd_d    = pcq_rd_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;

        if (fire) out_d = out_d + OW'(1);
        if (resp) out_d = out_d - OW'(1);

        if (br_valid) begin
            // Everything in flight becomes stale; the count already covers cancelled ones.
            cancel_d = out_q;
            if (fire) cancel_d = cancel_d + OW'(1);
            if (resp) cancel_d = cancel_d - OW'(1);
            fetch_pc_d = {br_target[31:2], 2'b00};
            if (inst_sram_req && !inst_sram_addr_ok) begin
                stale_d = 1'b1;
                if (!stale_q) stale_pc_d = fetch_pc_q;
            end else begin
                stale_d = 1'b0;
            end
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (fire && stale_q) cancel_d = cancel_d + OW'(1);
            if (resp && (cancel_q != '0)) cancel_d = cancel_d - OW'(1);
            if (fire) begin
                stale_d = 1'b0;
                if (!stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (live_fire) begin
                pcq_d[pcq_wr_q] = fetch_pc_q;
                pcq_wr_d = (pcq_wr_q == Q_LAST) ? '0 : pcq_wr_q + QW'(1);
            end
            if (live_resp) begin
                pcq_rd_d = (pcq_rd_q == Q_LAST) ? '0 : pcq_rd_q + QW'(1);
                fifo_pc_d[fifo_wr_q]   = pcq_q[pcq_rd_q];
                fifo_inst_d[fifo_wr_q] = inst_sram_rdata;
                fifo_wr_d  = fifo_wr_q + FW'(1);
                fifo_cnt_d = fifo_cnt_d + CW'(1);
            end
            if (pop) begin
                fifo_rd_d  = fifo_rd_q + FW'(1);
                fifo_cnt_d = fifo_cnt_d - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            stale_q     <= 1'b0;
            stale_pc_q  <= '0;
            pending_q   <= 1'b0;
            out_q       <= '0;
            cancel_q    <= '0;
            pcq_q       <= '{default: '0};
            pcq_wr_q    <= '0;
            pcq_rd_q    <= '0;
            fifo_pc_q   <= '{default: '0};
            fifo_inst_q <= '{default: '0};
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            stale_q     <= stale_d;
            stale_pc_q  <= stale_pc_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            cancel_q    <= cancel_d;
            pcq_q       <= pcq_d;
            pcq_wr_q    <= pcq_wr_d;
            pcq_rd_q    <= pcq_rd_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // A response with nothing in flight means the slave and this block disagree.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        !(inst_sram_data_ok && (out_q == '0)));

endmodule
